param_gate_sweeper: RTL
=======================

Name: param_gate_sweeper

Overview:
- Parametrised N-input logic gate with run-time selectable function (AND/OR/XOR/NAND/NOR/XNOR) and a registered output.
- Contains a built-in exhaustive sweep engine. It walks all 2^N_IN input combinations, holds each for a programmable number of cycles, and counts how many patterns drive the output high.
- Used as the reusable gate primitive for the toy-project series and as a self-checking truth-table generator.

Parameters:
- N_IN, 3, number of gate inputs; legal range 2..16.
- STEP_CYCLES, 1, cycles each sweep pattern is held before its result registers; legal range >=1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  3  function select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved (result 0).
- ext_in  input  N_IN  external operand.
- ext_valid  input  1  sample ext_in this cycle (honoured only in IDLE).
- sweep_start  input  1  launch exhaustive sweep (honoured only in IDLE).
- out  output  1  registered gate result.
- out_valid  output  1  one-cycle pulse per new result.
- cur_pattern  output  N_IN  pattern currently applied by the sweep engine.
- sweep_busy  output  1  high while in SWEEP.
- sweep_done  output  1  one-cycle pulse at end of sweep.
- ones_count  output  N_IN+1  number of sweep patterns that gave out=1.

Behaviour:
- Reset (async, any time, including mid-sweep): state=IDLE and every output is 0. This covers out, out_valid, cur_pattern, sweep_busy, sweep_done and ones_count, plus the internal hold counter and latched mode. No partial result is emitted after reset releases.
- States: IDLE, SWEEP, DONE.
- f(m,x) is the reduction of x selected by m. NAND/NOR/XNOR are the inversions of AND/OR/XOR. Reserved modes give 0.
- IDLE operation:
  - ext_valid=1 at edge k: out<=f(mode,ext_in) and out_valid=1 during cycle k+1 (latency 1). ones_count is untouched.
  - sweep_start=1 at edge k: state<=SWEEP, mode_q<=mode, cur_pattern<=0, hold_cnt<=0, ones_count<=0. No out_valid is generated at this edge.
  - sweep_start and ext_valid together: sweep_start wins and ext_in is ignored.
- SWEEP operation:
  - mode_q is frozen; mode changes are ignored until the next start.
  - Edge with hold_cnt < STEP_CYCLES-1: hold_cnt increments; out_valid=0 the following cycle.
  - Edge with hold_cnt == STEP_CYCLES-1, all of the following happen:
    - out<=f(mode_q,cur_pattern); out_valid pulses the following cycle.
    - ones_count += f.
    - hold_cnt<=0.
    - If cur_pattern == 2^N_IN-1, state<=DONE and cur_pattern wraps to 0; otherwise cur_pattern increments.
  - ext_valid and sweep_start are ignored.
- DONE: lasts exactly one cycle. sweep_done=1, coinciding with the final out_valid pulse. ones_count already holds the final value. Next state is IDLE; sweep_busy=0.
- sweep_busy = (state==SWEEP). Start request is ignored during DONE.
- Sweep duration: STEP_CYCLES*2^N_IN cycles from start edge to final result edge.
- ones_count holds its value in IDLE until the next sweep_start or reset. Width N_IN+1 holds the maximum 2^N_IN without overflow.
- Expected final counts:
  - AND 1, OR 2^N-1, XOR 2^(N-1).
  - NAND 2^N-1, NOR 1, XNOR 2^(N-1).
  - Reserved 0.

Test Plan:
- N_IN=3, STEP_CYCLES=1, ext mode: mode=1 (OR), drive ext_in = 000, 001, …, 111 on consecutive cycles with ext_valid=1 -> out sequence 0,1,1,1,1,1,1,1, each 1 cycle after input, 8 out_valid pulses; ones_count stays 0.
- N_IN=3, mode=1 sweep -> 8 out_valid pulses with out=0,1,1,1,1,1,1,1; sweep_done in the cycle of the 8th pulse; ones_count=7; sweep_busy high for exactly 8 cycles.
- N_IN=3 sweeps for modes 0,2,3,4,5,6 -> ones_count = 1, 4, 7, 1, 4, 0 respectively. Change mode mid-sweep and confirm no effect.
- N_IN=4, STEP_CYCLES=2, mode=2 -> cur_pattern steps every 2 cycles; 16 out_valid pulses spaced 2 cycles apart; sweep lasts 32 cycles; ones_count=8.
- Assert sweep_start and ext_valid during SWEEP, and sweep_start during DONE -> no restart, no extra out_valid, ones_count unaffected.
- Assert rst asynchronously (between edges) at pattern 5 of an N_IN=3 sweep -> all outputs 0 immediately. After release: no out_valid, no sweep_done, state IDLE, and a new sweep_start runs a full clean sweep.

Source files
------------

// File: rtl/param_gate_sweeper.sv
// N-input gate with run-time selectable function and a registered output.
// A built-in sweep engine walks every input pattern and counts the ones it produces.
module param_gate_sweeper #(
  parameter int N_IN        = 3,
  parameter int STEP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] ext_in,
  input  logic            ext_valid,
  input  logic            sweep_start,
  output logic            out,
  output logic            out_valid,
  output logic [N_IN-1:0] cur_pattern,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   ones_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int HW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(STEP_CYCLES - 1);
  localparam logic [N_IN-1:0] PAT_LAST  = '1;

  // Reserved modes 6/7 deliberately resolve to 0.
  function automatic logic gate_fn(input logic [2:0] m, input logic [N_IN-1:0] x);
    logic r;
    case (m)
      3'd0:    r = &x;
      3'd1:    r = |x;
      3'd2:    r = ^x;
      3'd3:    r = ~&x;
      3'd4:    r = ~|x;
      3'd5:    r = ~^x;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t          state_r;
  logic [2:0]      mode_r;
  logic [HW-1:0]   hold_r;
  logic            sweep_bit_s;

  assign sweep_bit_s = gate_fn(mode_r, cur_pattern);

  // Control FSM; every output is a register so nothing glitches downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= 3'd0;
      hold_r      <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      cur_pattern <= '0;
      sweep_busy  <= 1'b0;
      sweep_done  <= 1'b0;
      ones_count  <= '0;
    end else begin
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sweep_start) begin
            state_r     <= ST_SWEEP;
            mode_r      <= mode;
            cur_pattern <= '0;
            hold_r      <= '0;
            ones_count  <= '0;
            sweep_busy  <= 1'b1;
          end else if (ext_valid) begin
            out       <= gate_fn(mode, ext_in);
            out_valid <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (hold_r == HOLD_LAST) begin
            out        <= sweep_bit_s;
            out_valid  <= 1'b1;
            ones_count <= ones_count + (N_IN+1)'(sweep_bit_s);
            hold_r     <= '0;
            if (cur_pattern == PAT_LAST) begin
              state_r     <= ST_DONE;
              cur_pattern <= '0;
              sweep_busy  <= 1'b0;
              sweep_done  <= 1'b1;
            end else begin
              cur_pattern <= cur_pattern + N_IN'(1);
            end
          end else begin
            hold_r <= hold_r + HW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
